// File: rtl/ps2_arrow_decoder_if.sv
// Decoder result bundle: direction select, held status and event pulses.
// The decoder drives it through the master modport; consumers use slave.
interface ps2_arrow_decoder_if;
   logic [1:0] sel;
   logic       key_down;
   logic       dir_strobe;
   logic       frame_err;

   modport master (output sel, output key_down, output dir_strobe, output frame_err);
   modport slave  (input  sel, input  key_down, input  dir_strobe, input  frame_err);
endinterface

// File: rtl/ps2_arrow_decoder.sv
// Receive-only PS/2 front end: synchronise, deframe 11-bit frames, decode set-2 arrow make/break.
// Optional macro PS2_WASD_EN adds non-extended W/S/A/D decoding that shares the arrow held bits.
module ps2_arrow_decoder #(
   parameter int TIMEOUT_CYC = 20000,
   parameter int SYNC_STAGES = 2
) (
   input  logic                clk,
   input  logic                rst,
   inout  wire                 PS2_CLK,
   inout  wire                 PS2_DATA,
   ps2_arrow_decoder_if.master dec
);
   localparam int            TW      = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT_CYC);
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

   typedef enum logic { RX_IDLE, RX_SHIFT } rx_state_t;
   typedef enum logic [1:0] { D_IDLE, D_EXT, D_BRK, D_EXTBRK } dec_state_t;

   // PS/2 lines are open-collector and only ever read here; this block never drives them.
   logic [SYNC_STAGES-1:0] clk_sync_reg;
   logic [SYNC_STAGES-1:0] data_sync_reg;

   genvar gi;
   generate
      for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
         if (gi == 0) begin : g_first
            always_ff @(posedge clk or negedge rst) begin
               if (!rst) begin
                  clk_sync_reg[0]  <= 1'b1;
                  data_sync_reg[0] <= 1'b1;
               end else begin
                  clk_sync_reg[0]  <= PS2_CLK;
                  data_sync_reg[0] <= PS2_DATA;
               end
            end
         end else begin : g_next
            always_ff @(posedge clk or negedge rst) begin
               if (!rst) begin
                  clk_sync_reg[gi]  <= 1'b1;
                  data_sync_reg[gi] <= 1'b1;
               end else begin
                  clk_sync_reg[gi]  <= clk_sync_reg[gi-1];
                  data_sync_reg[gi] <= data_sync_reg[gi-1];
               end
            end
         end
      end
   endgenerate

   logic ps2_clk_s;
   logic ps2_data_s;
   logic clk_prev_reg;
   logic fall_edge;

   assign ps2_clk_s  = clk_sync_reg[SYNC_STAGES-1];
   assign ps2_data_s = data_sync_reg[SYNC_STAGES-1];
   assign fall_edge  = clk_prev_reg & ~ps2_clk_s;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) clk_prev_reg <= 1'b1;
      else      clk_prev_reg <= ps2_clk_s;
   end

   // Frame receiver; byte_rdy_reg / rx_err_reg pulse the cycle after the stop edge.
   rx_state_t     rx_state_reg;
   logic [3:0]    bit_cnt_reg;
   logic [7:0]    shift_reg;
   logic          parity_reg;
   logic [TW-1:0] timeout_reg;
   logic [7:0]    byte_reg;
   logic          byte_rdy_reg;
   logic          rx_err_reg;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_state_reg <= RX_IDLE;
         bit_cnt_reg  <= 4'd0;
         shift_reg    <= 8'd0;
         parity_reg   <= 1'b0;
         timeout_reg  <= '0;
         byte_reg     <= 8'd0;
         byte_rdy_reg <= 1'b0;
         rx_err_reg   <= 1'b0;
      end else begin
         byte_rdy_reg <= 1'b0;
         rx_err_reg   <= 1'b0;

         if (fall_edge)
            timeout_reg <= '0;
         else if (rx_state_reg == RX_SHIFT && timeout_reg != TO_MAX)
            timeout_reg <= timeout_reg + 1'b1;

         case (rx_state_reg)
            RX_IDLE: begin
               if (fall_edge) begin
                  if (!ps2_data_s) begin
                     rx_state_reg <= RX_SHIFT;
                     bit_cnt_reg  <= 4'd1;
                  end else begin
                     rx_err_reg <= 1'b1;
                  end
               end
            end
            RX_SHIFT: begin
               if (fall_edge) begin
                  bit_cnt_reg <= bit_cnt_reg + 4'd1;
                  if (bit_cnt_reg <= 4'd8) begin
                     shift_reg <= {ps2_data_s, shift_reg[7:1]};
                  end else if (bit_cnt_reg == 4'd9) begin
                     parity_reg <= ps2_data_s;
                  end else begin
                     rx_state_reg <= RX_IDLE;
                     bit_cnt_reg  <= 4'd0;
                     if ((^{shift_reg, parity_reg}) && ps2_data_s) begin
                        byte_rdy_reg <= 1'b1;
                        byte_reg     <= shift_reg;
                     end else begin
                        rx_err_reg <= 1'b1;
                     end
                  end
               end else if (timeout_reg == TO_LAST) begin
                  rx_state_reg <= RX_IDLE;
                  bit_cnt_reg  <= 4'd0;
                  rx_err_reg   <= 1'b1;
               end
            end
            default: rx_state_reg <= RX_IDLE;
         endcase
      end
   end

   logic       arrow_hit;
   logic       wasd_hit;
   logic [1:0] code_dir;

   always_comb begin
      arrow_hit = 1'b0;
      wasd_hit  = 1'b0;
      code_dir  = 2'b00;
      case (byte_reg)
         8'h75: begin arrow_hit = 1'b1; code_dir = 2'b00; end
         8'h72: begin arrow_hit = 1'b1; code_dir = 2'b01; end
         8'h6B: begin arrow_hit = 1'b1; code_dir = 2'b10; end
         8'h74: begin arrow_hit = 1'b1; code_dir = 2'b11; end
`ifdef PS2_WASD_EN
         8'h1D: begin wasd_hit = 1'b1; code_dir = 2'b00; end
         8'h1B: begin wasd_hit = 1'b1; code_dir = 2'b01; end
         8'h1C: begin wasd_hit = 1'b1; code_dir = 2'b10; end
         8'h23: begin wasd_hit = 1'b1; code_dir = 2'b11; end
`else
`endif
         default: ;
      endcase
   end

   dec_state_t dec_state_reg;
   logic [1:0] sel_reg;
   logic [3:0] held_reg;
   logic [3:0] held_next;
   logic       key_down_reg;
   logic       dir_strobe_reg;
   logic       make_hit;
   logic       brk_hit;

   always_comb begin
      make_hit  = 1'b0;
      brk_hit   = 1'b0;
      if (byte_rdy_reg) begin
         case (dec_state_reg)
            D_IDLE:   make_hit = wasd_hit;
            D_EXT:    make_hit = arrow_hit;
            D_BRK:    brk_hit  = wasd_hit;
            D_EXTBRK: brk_hit  = arrow_hit;
            default:  ;
         endcase
      end
      held_next = held_reg;
      if (make_hit) held_next[code_dir] = 1'b1;
      if (brk_hit)  held_next[code_dir] = 1'b0;
   end

   // Decoder sees byte_rdy in N+1, so sel / dir_strobe / key_down land in N+2.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dec_state_reg  <= D_IDLE;
         sel_reg        <= 2'b00;
         held_reg       <= 4'd0;
         key_down_reg   <= 1'b0;
         dir_strobe_reg <= 1'b0;
      end else begin
         dir_strobe_reg <= 1'b0;
         held_reg       <= held_next;
         key_down_reg   <= |held_next;
         if (make_hit) begin
            sel_reg        <= code_dir;
            dir_strobe_reg <= 1'b1;
         end

         if (rx_err_reg) begin
            dec_state_reg <= D_IDLE;
         end else if (byte_rdy_reg) begin
            case (dec_state_reg)
               D_IDLE: begin
                  if (byte_reg == 8'hE0)      dec_state_reg <= D_EXT;
                  else if (byte_reg == 8'hF0) dec_state_reg <= D_BRK;
                  else                        dec_state_reg <= D_IDLE;
               end
               D_EXT: begin
                  if (byte_reg == 8'hF0)      dec_state_reg <= D_EXTBRK;
                  else if (byte_reg == 8'hE0) dec_state_reg <= D_EXT;
                  else                        dec_state_reg <= D_IDLE;
               end
               D_BRK:    dec_state_reg <= D_IDLE;
               D_EXTBRK: dec_state_reg <= D_IDLE;
               default:  dec_state_reg <= D_IDLE;
            endcase
         end
      end
   end

   assign dec.sel        = sel_reg;
   assign dec.key_down   = key_down_reg;
   assign dec.dir_strobe = dir_strobe_reg;
   assign dec.frame_err  = rx_err_reg;
endmodule
